// File: rtl/manchester_encoder_100m_if.sv
// manchester_encoder_100m_if: packer-to-encoder bit handshake plus line and status signals
interface manchester_encoder_100m_if;
  logic       tx_en;
  logic       tx_bit;
  logic       tx_bit_valid;
  logic       tx_bit_ready;
  logic       line_out;
  logic       line_active;
  logic       overflow;
  logic [7:0] underrun_cnt;
  modport master (
    output tx_en, tx_bit, tx_bit_valid,
    input  tx_bit_ready, line_out, line_active, overflow, underrun_cnt
  );
  modport slave (
    input  tx_en, tx_bit, tx_bit_valid,
    output tx_bit_ready, line_out, line_active, overflow, underrun_cnt
  );
endinterface

// File: rtl/manchester_encoder_100m.sv
// manchester_encoder_100m: bit FIFO feeding a Manchester line encoder with backpressure and status
module manchester_encoder_100m #(
  parameter int   CLKS_PER_HALF = 2,
  parameter int   DEPTH         = 4,
  parameter logic IDLE_LEVEL    = 1'b0
) (
  input logic clk_sys,
  input logic rst_n,
  manchester_encoder_100m_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int HW = (CLKS_PER_HALF > 1) ? $clog2(CLKS_PER_HALF) : 1;
  typedef enum logic [1:0] {IDLE, HALF1, HALF2} state_t;
  state_t          state_q;
  logic [DEPTH-1:0] mem_q;
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [AW:0]     count_q, count_d;
  logic [HW-1:0]   half_q;
  logic            bit_q, line_q, active_q, overflow_q;
  logic [7:0]      underrun_q;
  logic            empty, full, half_end, pop, push;
  assign empty    = count_q == '0;
  assign full     = count_q == (AW+1)'(DEPTH);
  assign half_end = half_q == HW'(CLKS_PER_HALF - 1);
  assign pop      = !empty && bus.tx_en && (state_q == IDLE || (state_q == HALF2 && half_end));
  assign push     = bus.tx_bit_valid && (!full || pop);
  assign count_d  = count_q + (AW+1)'(push) - (AW+1)'(pop);
  // Ready leaves room for the bit the packer may already have in flight.
  assign bus.tx_bit_ready = bus.tx_en &&
    (({1'b0, count_q} + (AW+2)'(bus.tx_bit_valid)) <= (AW+2)'(DEPTH - 2));
  assign bus.line_out     = line_q;
  assign bus.line_active  = active_q;
  assign bus.overflow     = overflow_q;
  assign bus.underrun_cnt = underrun_q;
  always_ff @(posedge clk_sys or negedge rst_n)
    if (!rst_n) begin
      mem_q      <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= bus.tx_bit;
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_d;
      if (bus.tx_bit_valid && full && !pop) overflow_q <= 1'b1;
    end
  always_ff @(posedge clk_sys or negedge rst_n)
    if (!rst_n) begin
      state_q    <= IDLE;
      half_q     <= '0;
      bit_q      <= 1'b0;
      line_q     <= IDLE_LEVEL;
      active_q   <= 1'b0;
      underrun_q <= '0;
    end else if (pop) begin
      state_q  <= HALF1;
      half_q   <= '0;
      bit_q    <= mem_q[rd_ptr_q];
      line_q   <= !mem_q[rd_ptr_q];
      active_q <= 1'b1;
    end else if (state_q != IDLE && !half_end) begin
      half_q <= half_q + HW'(1);
    end else if (state_q == HALF1) begin
      state_q <= HALF2;
      half_q  <= '0;
      line_q  <= bit_q;
    end else if (state_q == HALF2) begin
      state_q  <= IDLE;
      half_q   <= '0;
      line_q   <= IDLE_LEVEL;
      active_q <= 1'b0;
      if (bus.tx_en) underrun_q <= underrun_q + 8'd1;
    end
endmodule

// File: tb/tb_manchester_encoder_100m.sv
// tb_manchester_encoder_100m: scoreboard bench for the Manchester encoder at default and 1-cycle half-bit builds
module tb_manchester_encoder_100m;
  localparam int CPH = 2;
  logic clk_sys = 1'b0;
  logic rst_n   = 1'b0;
  always #5 clk_sys = ~clk_sys;
  manchester_encoder_100m_if bus ();
  manchester_encoder_100m_if bus2 ();
  manchester_encoder_100m #(.CLKS_PER_HALF(CPH), .DEPTH(4), .IDLE_LEVEL(1'b0)) dut (
    .clk_sys(clk_sys), .rst_n(rst_n), .bus(bus.slave));
  manchester_encoder_100m #(.CLKS_PER_HALF(1), .DEPTH(4), .IDLE_LEVEL(1'b0)) dut2 (
    .clk_sys(clk_sys), .rst_n(rst_n), .bus(bus2.slave));
  int   checks   = 0;
  int   failures = 0;
  logic exp_q[$];
  logic lvl_q[$];
  int   phase = 0;
  logic cur   = 1'b0;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic cyc();
    @(posedge clk_sys);
    #1;
  endtask
  task automatic drv(input logic v, input logic b);
    cyc();
    bus.tx_bit_valid = v;
    bus.tx_bit       = b;
  endtask
  task automatic wait_idle(input string tag);
    int n = 0;
    while ((bus.line_active || exp_q.size() != 0) && n < 500) begin
      @(negedge clk_sys);
      n++;
    end
    chk(tag, n < 500, 1);
  endtask
  task automatic burst(input string tag, input int exp);
    int n = 0;
    int w = 0;
    while (!bus.line_active && w < 50) begin
      @(negedge clk_sys);
      w++;
    end
    while (bus.line_active && n < 1000) begin
      @(negedge clk_sys);
      n++;
    end
    chk(tag, n, exp);
  endtask
  // Decode the line bit by bit against the queue of bits the bench expects to be sent.
  always @(negedge clk_sys) begin
    if (!rst_n) phase = 0;
    else if (phase == 0) begin
      if (bus.line_active) begin
        if (exp_q.size() == 0) chk("unexpected_bit", bus.line_active, 0);
        else begin
          cur = exp_q.pop_front();
          chk("half1_start", bus.line_out, !cur);
          phase = 1;
        end
      end else chk("idle_level", bus.line_out, 0);
    end else begin
      chk("active_mid_bit", bus.line_active, 1);
      chk("manchester_level", bus.line_out, phase < CPH ? !cur : cur);
      phase = (phase == 2 * CPH - 1) ? 0 : phase + 1;
    end
  end
  initial begin
    #100000;
    $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end
  initial begin
    logic [55:0] frame;
    logic [6:0]  b3;
    logic        rdy;
    int          idx;
    int          g;
    bus.tx_en = 1'b0; bus.tx_bit = 1'b0; bus.tx_bit_valid = 1'b0;
    bus2.tx_en = 1'b0; bus2.tx_bit = 1'b0; bus2.tx_bit_valid = 1'b0;
    repeat (2) cyc();
    chk("rst_line_out", bus.line_out, 0);
    chk("rst_active", bus.line_active, 0);
    chk("rst_overflow", bus.overflow, 0);
    chk("rst_underrun", bus.underrun_cnt, 0);
    chk("rst_ready_en0", bus.tx_bit_ready, 0);
    rst_n = 1'b1;
    bus.tx_en = 1'b1;
    bus2.tx_en = 1'b1;
    #1;
    chk("ready_empty", bus.tx_bit_ready, 1);
    // single bit 1: low half on t+2..t+3, high on t+4..t+5
    drv(1'b1, 1'b1);
    exp_q.push_back(1'b1);
    #1;
    chk("ready_one_in", bus.tx_bit_ready, 1);
    drv(1'b0, 1'b0);
    @(negedge clk_sys);
    chk("lat_t1_idle", bus.line_active, 0);
    @(negedge clk_sys);
    chk("lat_t2_active", bus.line_active, 1);
    chk("lat_t2_low", bus.line_out, 0);
    wait_idle("single_idle");
    chk("single_underrun", bus.underrun_cnt, 1);
    // packer-style 56-bit frame
    frame = {8'hAA, 8'h00, 32'h12345678, 8'hC3};
    idx = 0;
    fork
      begin
        rdy = bus.tx_bit_ready;
        g = 0;
        while (idx < 56 && g < 2000) begin
          cyc();
          bus.tx_bit_valid = rdy;
          bus.tx_bit = frame[55 - idx];
          if (rdy) begin
            exp_q.push_back(frame[55 - idx]);
            idx++;
          end
          @(negedge clk_sys);
          rdy = bus.tx_bit_ready;
          g++;
        end
        cyc();
        bus.tx_bit_valid = 1'b0;
      end
      burst("frame_len", 224);
    join
    chk("frame_overflow", bus.overflow, 0);
    chk("frame_underrun", bus.underrun_cnt, 2);
    wait_idle("frame_idle");
    // continuous valid ignoring ready: 6 accepted, 7th dropped
    b3 = 7'b1011001;
    for (int i = 0; i < 7; i++) begin
      drv(1'b1, b3[i]);
      if (i < 6) exp_q.push_back(b3[i]);
      @(negedge clk_sys);
      if (i == 6) chk("ovf_not_on_pop_write", bus.overflow, 0);
    end
    drv(1'b0, 1'b0);
    @(negedge clk_sys);
    chk("ovf_set", bus.overflow, 1);
    wait_idle("ovf_idle");
    chk("ovf_sticky", bus.overflow, 1);
    chk("ovf_underrun", bus.underrun_cnt, 3);
    // disable during HALF1 with 3 bits queued
    for (int i = 0; i < 4; i++) begin
      drv(1'b1, i[0] ^ i[1]);
      exp_q.push_back(i[0] ^ i[1]);
      if (i == 3) bus.tx_en = 1'b0;
    end
    drv(1'b0, 1'b0);
    repeat (10) @(negedge clk_sys);
    chk("dis_idle", bus.line_active, 0);
    chk("dis_ready", bus.tx_bit_ready, 0);
    chk("dis_underrun", bus.underrun_cnt, 3);
    cyc();
    bus.tx_en = 1'b1;
    burst("resume_len", 12);
    chk("resume_underrun", bus.underrun_cnt, 4);
    wait_idle("resume_idle");
    // asynchronous reset in HALF2 with bits still queued
    drv(1'b1, 1'b1); exp_q.push_back(1'b1);
    drv(1'b1, 1'b1); exp_q.push_back(1'b1);
    drv(1'b1, 1'b0); exp_q.push_back(1'b0);
    drv(1'b0, 1'b0);
    cyc();
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    chk("arst_line", bus.line_out, 0);
    chk("arst_active", bus.line_active, 0);
    chk("arst_overflow", bus.overflow, 0);
    chk("arst_underrun", bus.underrun_cnt, 0);
    repeat (2) cyc();
    rst_n = 1'b1;
    repeat (10) @(negedge clk_sys);
    chk("arst_stays_idle", bus.line_active, 0);
    chk("arst_ready", bus.tx_bit_ready, 1);
    drv(1'b1, 1'b0);
    exp_q.push_back(1'b0);
    drv(1'b0, 1'b0);
    wait_idle("post_rst_idle");
    chk("post_rst_underrun", bus.underrun_cnt, 1);
    // CLKS_PER_HALF=1 build: bits 1,0,1,0
    for (int i = 0; i < 12; i++) begin
      cyc();
      bus2.tx_bit_valid = i < 4;
      bus2.tx_bit = !i[0];
      if (i < 4) begin
        lvl_q.push_back(i[0]);
        lvl_q.push_back(!i[0]);
      end
      @(negedge clk_sys);
      if (i >= 2 && i < 10) chk("cph1_level", bus2.line_out, lvl_q.pop_front());
      chk("cph1_active", bus2.line_active, i >= 2 && i < 10);
    end
    bus2.tx_bit_valid = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
